// File: rtl/trail_map_pkg.sv
// Shared definitions for the trail map: playfield geometry, coordinate and
// cell-address widths, FSM state encoding, player ids and the cell-address
// helper used by the map controller.
package trail_map_pkg;

    localparam int unsigned SCR_W       = 160;
    localparam int unsigned SCR_H       = 120;
    localparam int unsigned X_W         = 8;
    localparam int unsigned Y_W         = 7;
    localparam int unsigned CELL_ADDR_W = 15;
    localparam int unsigned CELLS       = SCR_W * SCR_H;

    localparam logic [X_W-1:0]         X_LIMIT   = X_W'(SCR_W);
    localparam logic [Y_W-1:0]         Y_LIMIT   = Y_W'(SCR_H);
    localparam logic [CELL_ADDR_W-1:0] LAST_CELL = CELL_ADDR_W'(CELLS - 1);

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_READ  = 2'd2,
        S_CHECK = 2'd3
    } state_e;

    // y*160 + x built from shifts: y*128 + y*32 + x
    function automatic logic [CELL_ADDR_W-1:0] cell_addr(input logic [X_W-1:0] x,
                                                         input logic [Y_W-1:0] y);
        logic [CELL_ADDR_W-1:0] yy;
        yy = CELL_ADDR_W'(y);
        return (yy << 7) + (yy << 5) + CELL_ADDR_W'(x);
    endfunction

endpackage

// File: rtl/trail_ram.sv
// Single-port synchronous occupancy RAM, one 2-bit word {occ, owner} per cell.
// Ports:
//   clk    system clock
//   we     write enable
//   addr   cell address
//   wdata  word to write
//   rdata  word at addr, registered (one-cycle read latency)
// Contents are not reset; the controller's sweep initialises them.
module trail_ram
    import trail_map_pkg::*;
(
    input  logic                   clk,
    input  logic                   we,
    input  logic [CELL_ADDR_W-1:0] addr,
    input  logic [1:0]             wdata,
    output logic [1:0]             rdata
);

    logic [1:0] mem [CELLS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/trail_map.sv
// Trail occupancy map: consumes plot requests {x, y, player}, reports wall or
// trail collisions and records free cells. Sweeps the map to empty after reset
// and on every clear_req.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   clear_req            start a new-round sweep
//   plot_valid/ready     request handshake; plot_x, plot_y, plot_player payload
//   res_valid            one-cycle result pulse with res_collide/res_wall/res_owner
//   clearing             sweep in progress
//   clear_done           one-cycle pulse when the sweep finishes
module trail_map
    import trail_map_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    input  logic           clear_req,
    input  logic           plot_valid,
    output logic           plot_ready,
    input  logic [X_W-1:0] plot_x,
    input  logic [Y_W-1:0] plot_y,
    input  logic           plot_player,
    output logic           res_valid,
    output logic           res_collide,
    output logic           res_wall,
    output logic           res_owner,
    output logic           clearing,
    output logic           clear_done
);

    state_e                 state_q, state_d;
    logic [CELL_ADDR_W-1:0] sweep_q, sweep_d;
    logic [X_W-1:0]         x_q;
    logic [Y_W-1:0]         y_q;
    logic                   player_q;
    logic                   accept;

    logic res_valid_q, res_valid_d;
    logic res_collide_q, res_collide_d;
    logic res_wall_q, res_wall_d;
    logic res_owner_q, res_owner_d;
    logic clear_done_q, clear_done_d;

    logic                   ram_we;
    logic [CELL_ADDR_W-1:0] ram_addr;
    logic [1:0]             ram_wdata;
    logic [1:0]             ram_rdata;

    logic                   wall;
    logic                   occ;
    logic [CELL_ADDR_W-1:0] plot_addr;

    assign wall      = (x_q >= X_LIMIT) | (y_q >= Y_LIMIT);
    // Off-field coordinates would index past the RAM; park them on cell 0.
    assign plot_addr = wall ? '0 : cell_addr(x_q, y_q);
    assign occ       = ram_rdata[1];

    trail_ram u_trail_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d       = state_q;
        sweep_d       = sweep_q;
        accept        = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = plot_addr;
        ram_wdata     = 2'b00;
        res_valid_d   = 1'b0;
        res_collide_d = 1'b0;
        res_wall_d    = 1'b0;
        res_owner_d   = 1'b0;
        clear_done_d  = 1'b0;

        unique case (state_q)
            S_CLEAR: begin
                ram_we   = 1'b1;
                ram_addr = sweep_q;
                if (clear_req) begin
                    sweep_d = '0;
                end else if (sweep_q == LAST_CELL) begin
                    sweep_d      = '0;
                    state_d      = S_IDLE;
                    clear_done_d = 1'b1;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (clear_req) begin
                    sweep_d = '0;
                    state_d = S_CLEAR;
                end else if (plot_valid) begin
                    accept  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // A cell is claimed only once; hits never overwrite the owner.
                ram_we        = !wall && !occ;
                ram_wdata     = {1'b1, player_q};
                res_valid_d   = 1'b1;
                res_collide_d = wall | occ;
                res_wall_d    = wall;
                res_owner_d   = occ & !wall & ram_rdata[0];
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_CLEAR;
                sweep_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_CLEAR;
            sweep_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            player_q      <= P1;
            res_valid_q   <= 1'b0;
            res_collide_q <= 1'b0;
            res_wall_q    <= 1'b0;
            res_owner_q   <= 1'b0;
            clear_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            sweep_q       <= sweep_d;
            res_valid_q   <= res_valid_d;
            res_collide_q <= res_collide_d;
            res_wall_q    <= res_wall_d;
            res_owner_q   <= res_owner_d;
            clear_done_q  <= clear_done_d;
            if (accept) begin
                x_q      <= plot_x;
                y_q      <= plot_y;
                player_q <= plot_player;
            end
        end
    end

    assign plot_ready  = (state_q == S_IDLE);
    assign clearing    = (state_q == S_CLEAR);
    assign clear_done  = clear_done_q;
    assign res_valid   = res_valid_q;
    assign res_collide = res_collide_q;
    assign res_wall    = res_wall_q;
    assign res_owner   = res_owner_q;

endmodule

// File: tb/tb_trail_map.sv
module tb_trail_map;

    logic       clk = 1'b0;
    logic       resetn;
    logic       clear_req;
    logic       plot_valid;
    logic       plot_ready;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic       plot_player;
    logic       res_valid;
    logic       res_collide;
    logic       res_wall;
    logic       res_owner;
    logic       clearing;
    logic       clear_done;

    trail_map dut (
        .clk         (clk),
        .resetn      (resetn),
        .clear_req   (clear_req),
        .plot_valid  (plot_valid),
        .plot_ready  (plot_ready),
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_player (plot_player),
        .res_valid   (res_valid),
        .res_collide (res_collide),
        .res_wall    (res_wall),
        .res_owner   (res_owner),
        .clearing    (clearing),
        .clear_done  (clear_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic collide;
        logic wall;
        logic owner;
        int   cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       e_mon;
    logic [1:0] mdl [0:19199];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: predicts the result and claims the cell when free.
    task automatic push_exp(input logic [7:0] x, input logic [6:0] y, input logic p,
                            input int at);
        exp_t e;
        int   a;
        e.cyc = at;
        if (x >= 8'd160 || y >= 7'd120) begin
            e.collide = 1'b1;
            e.wall    = 1'b1;
            e.owner   = 1'b0;
        end else begin
            a         = int'(y) * 160 + int'(x);
            e.wall    = 1'b0;
            e.collide = mdl[a][1];
            e.owner   = mdl[a][1] & mdl[a][0];
            if (!mdl[a][1]) mdl[a] = {1'b1, p};
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (res_valid) begin
                if (sb.size() == 0) begin
                    chk("unexp_res", 32'(sb.size()), 1);
                end else begin
                    e_mon = sb.pop_front();
                    chk("res_collide", 32'(res_collide), 32'(e_mon.collide));
                    chk("res_wall", 32'(res_wall), 32'(e_mon.wall));
                    chk("res_owner", 32'(res_owner), 32'(e_mon.owner));
                    chk("res_latency", cyc, e_mon.cyc);
                    chk("res_ready", 32'(plot_ready), 1);
                end
            end else begin
                chk("res_idle", {29'd0, res_collide, res_wall, res_owner}, 0);
            end
        end
    end

    task automatic wait_clear_done();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!clear_done && n < 25000);
        chk("clr_cycles", n, 19200);
        chk("clr_ready", 32'(plot_ready), 1);
        chk("clr_flag", 32'(clearing), 0);
        @(posedge clk);
        #1;
        chk("clr_pulse", 32'(clear_done), 0);
        for (int i = 0; i < 19200; i++) mdl[i] = 2'b00;
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!plot_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("wait_ready", 32'(plot_ready), 1);
    endtask

    task automatic do_plot(input logic [7:0] x, input logic [6:0] y, input logic p);
        wait_ready();
        plot_x      = x;
        plot_y      = y;
        plot_player = p;
        plot_valid  = 1'b1;
        push_exp(x, y, p, cyc + 3);
        @(posedge clk);
        #1;
        plot_valid = 1'b0;
        chk("busy_read", 32'(plot_ready), 0);
        @(posedge clk);
        #1;
        chk("busy_check", 32'(plot_ready), 0);
    endtask

    initial begin
        resetn      = 1'b0;
        clear_req   = 1'b0;
        plot_valid  = 1'b0;
        plot_x      = '0;
        plot_y      = '0;
        plot_player = 1'b0;
        #1;
        chk("rst_ready", 32'(plot_ready), 0);
        chk("rst_clearing", 32'(clearing), 1);
        chk("rst_done", 32'(clear_done), 0);
        chk("rst_res", {28'd0, res_valid, res_collide, res_wall, res_owner}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        wait_clear_done();

        // First claim, then hits from both players on the same cell.
        do_plot(8'd10, 7'd20, 1'b0);
        do_plot(8'd10, 7'd20, 1'b1);
        do_plot(8'd10, 7'd20, 1'b0);
        // Walls, far corner claim and repeat.
        do_plot(8'd160, 7'd5, 1'b1);
        do_plot(8'd5, 7'd120, 1'b0);
        do_plot(8'd159, 7'd119, 1'b1);
        do_plot(8'd159, 7'd119, 1'b0);
        do_plot(8'd0, 7'd0, 1'b1);
        do_plot(8'd0, 7'd0, 1'b1);

        // clear_req beats plot_valid; plots held during the sweep are ignored.
        wait_ready();
        @(posedge clk);
        #1;
        clear_req   = 1'b1;
        plot_valid  = 1'b1;
        plot_x      = 8'd30;
        plot_y      = 7'd40;
        plot_player = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        chk("clr_enter", 32'(clearing), 1);
        chk("clr_noready", 32'(plot_ready), 0);
        repeat (5000) @(posedge clk);
        #1;
        chk("clr_mid", 32'(clearing), 1);
        // Restart mid-sweep: a full sweep follows from this edge.
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req  = 1'b0;
        plot_valid = 1'b0;
        wait_clear_done();
        do_plot(8'd10, 7'd20, 1'b0);
        do_plot(8'd30, 7'd40, 1'b0);

        // Reset while a plot sits in S_READ: dropped, no result.
        wait_ready();
        plot_x      = 8'd70;
        plot_y      = 7'd70;
        plot_player = 1'b0;
        plot_valid  = 1'b1;
        @(posedge clk);
        #1;
        plot_valid = 1'b0;
        resetn     = 1'b0;
        #1;
        chk("rst2_ready", 32'(plot_ready), 0);
        chk("rst2_clearing", 32'(clearing), 1);
        chk("rst2_done", 32'(clear_done), 0);
        chk("rst2_res", {28'd0, res_valid, res_collide, res_wall, res_owner}, 0);
        @(negedge clk);
        resetn = 1'b1;
        wait_clear_done();
        do_plot(8'd70, 7'd70, 1'b1);

        // plot_valid held with changing coords: accepts every third cycle.
        wait_ready();
        plot_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            plot_x      = 8'(50 + (k % 6));
            plot_y      = 7'(1 + (k % 6));
            plot_player = (k < 3);
            chk("hold_ready", 32'(plot_ready), 32'(k % 3 == 0));
            if (k % 3 == 0) push_exp(plot_x, plot_y, plot_player, cyc + 3);
            @(posedge clk);
            #1;
        end
        plot_valid = 1'b0;

        repeat (6) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
